// File: rtl/pong_pkg.sv
// Shared constants and types for the Pong pixel renderer.
// PONG_BORDER_EN (when defined) enables the playfield border drawn in COLOR_BORDER.
package pong_pkg;

    localparam logic [7:0] COLOR_BALL   = 8'hFF;
    localparam logic [7:0] COLOR_PADDLE = 8'h1C;
    localparam logic [7:0] COLOR_BORDER = 8'hE0;
    localparam logic [7:0] COLOR_BG     = 8'h00;

    localparam int unsigned BORDER_W = 4;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        MISS
    } game_state_e;

endpackage

// File: rtl/pong_frame_renderer_if.sv
// Video timing, position, button and pixel/score bundle between the CRT controller,
// the renderer and the display side.
interface pong_frame_renderer_if #(
    parameter int unsigned ResolutionSize = 10
);

    logic                      hsync_in;
    logic                      vsync_in;
    logic [ResolutionSize-1:0] xposition;
    logic [ResolutionSize-1:0] yposition;
    logic [3:0]                btn;
    logic [7:0]                rgb;
    logic                      hsync_out;
    logic                      vsync_out;
    logic [3:0]                score_left;
    logic [3:0]                score_right;

    modport master (
        output hsync_in, vsync_in, xposition, yposition, btn,
        input  rgb, hsync_out, vsync_out, score_left, score_right
    );

    modport slave (
        input  hsync_in, vsync_in, xposition, yposition, btn,
        output rgb, hsync_out, vsync_out, score_left, score_right
    );

endinterface

// File: rtl/pong_paddle.sv
// One paddle: clamped vertical position updated on the frame tick, plus a
// combinational "pixel is on this paddle" flag for a fixed left edge.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int unsigned ResolutionSize = 10,
    parameter int unsigned YRES           = 480,
    parameter int unsigned PADDLE_X       = 16,
    parameter int unsigned PADDLE_W       = 8,
    parameter int unsigned PADDLE_H       = 64,
    parameter int unsigned PADDLE_SPEED   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick_i,
    input  logic                    up_i,
    input  logic                    down_i,
    input  logic [ResolutionSize:0] x_i,
    input  logic [ResolutionSize:0] y_i,
    output logic [ResolutionSize:0] py_o,
    output logic                    on_o
);

    typedef logic [ResolutionSize:0] coord_t;

    localparam coord_t PyMax = coord_t'(YRES - PADDLE_H);
    localparam coord_t PyRst = coord_t'((YRES - PADDLE_H) / 2);
    localparam coord_t Speed = coord_t'(PADDLE_SPEED);
    localparam coord_t PadX  = coord_t'(PADDLE_X);
    localparam coord_t PadW  = coord_t'(PADDLE_W);
    localparam coord_t PadH  = coord_t'(PADDLE_H);

    coord_t py_d, py_q;

    always_comb begin
        py_d = py_q;
        if (tick_i) begin
            // Opposing buttons cancel; clamp before the subtract so py never wraps.
            if (up_i && !down_i) begin
                py_d = (py_q <= Speed) ? '0 : py_q - Speed;
            end else if (down_i && !up_i) begin
                py_d = (py_q + Speed >= PyMax) ? PyMax : py_q + Speed;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            py_q <= PyRst;
        end else begin
            py_q <= py_d;
        end
    end

    assign py_o = py_q;
    assign on_o = (x_i >= PadX) && (x_i < PadX + PadW) && (y_i >= py_q) && (y_i < py_q + PadH);

endmodule

// File: rtl/pong_frame_renderer.sv
// Two-paddle Pong pixel generator: per-frame game FSM plus a registered RGB332 pixel
// aligned with re-registered syncs. PONG_BORDER_EN adds a border and moves the walls.
module pong_frame_renderer
    import pong_pkg::*;
#(
    parameter int unsigned ResolutionSize = 10,
    parameter int unsigned XRES           = 640,
    parameter int unsigned YRES           = 480,
    parameter int unsigned BALL_SIZE      = 8,
    parameter int unsigned BALL_SPEED     = 2,
    parameter int unsigned PADDLE_W       = 8,
    parameter int unsigned PADDLE_H       = 64,
    parameter int unsigned PADDLE_X       = 16,
    parameter int unsigned PADDLE_SPEED   = 4,
    parameter int unsigned SERVE_FRAMES   = 60
) (
    input logic                  clock,
    input logic                  reset,
    pong_frame_renderer_if.slave vid
);

    typedef logic [ResolutionSize:0] coord_t;

    localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);
    localparam int unsigned RPadXI = XRES - PADDLE_X - PADDLE_W;

    localparam coord_t XresC  = coord_t'(XRES);
    localparam coord_t YresC  = coord_t'(YRES);
    localparam coord_t BallSz = coord_t'(BALL_SIZE);
    localparam coord_t Speed  = coord_t'(BALL_SPEED);
    localparam coord_t PadH   = coord_t'(PADDLE_H);
    localparam coord_t BxCtr  = coord_t'(XRES / 2 - BALL_SIZE / 2);
    localparam coord_t ByCtr  = coord_t'(YRES / 2 - BALL_SIZE / 2);
    localparam coord_t HitL   = coord_t'(PADDLE_X + PADDLE_W + BALL_SPEED);
    localparam coord_t SnapL  = coord_t'(PADDLE_X + PADDLE_W);
    localparam coord_t HitR   = coord_t'(RPadXI - BALL_SIZE - BALL_SPEED);
    localparam coord_t SnapR  = coord_t'(RPadXI - BALL_SIZE);
    localparam coord_t MissR  = coord_t'(XRES - BALL_SIZE - BALL_SPEED);
`ifdef PONG_BORDER_EN
    localparam coord_t BorderC = coord_t'(BORDER_W);
    localparam coord_t WallTop = coord_t'(BORDER_W);
    localparam coord_t WallBot = coord_t'(YRES - BORDER_W);
`else
    localparam coord_t WallTop = '0;
    localparam coord_t WallBot = coord_t'(YRES);
`endif

    logic        hsync_q, vsync_q, vsync_prev_q;
    logic [7:0]  rgb_d, rgb_q;
    game_state_e state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    coord_t      bx_d, bx_q, by_d, by_q;
    logic        dx_d, dx_q;  // 1 = moving right
    logic        dy_d, dy_q;  // 1 = moving down
    logic        scorer_d, scorer_q;  // 1 = left player scored the pending miss
    logic [3:0]  score_l_d, score_l_q, score_r_d, score_r_q;

    coord_t x, y, lpy, rpy;
    logic   tick, on_lpad, on_rpad, on_ball, l_overlap, r_overlap;

    assign x    = {1'b0, vid.xposition};
    assign y    = {1'b0, vid.yposition};
    assign tick = vsync_prev_q & ~vsync_q;

    pong_paddle #(
        .ResolutionSize(ResolutionSize), .YRES(YRES), .PADDLE_X(PADDLE_X),
        .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
    ) u_paddle_left (
        .clock(clock), .reset(reset), .tick_i(tick), .up_i(vid.btn[0]), .down_i(vid.btn[1]),
        .x_i(x), .y_i(y), .py_o(lpy), .on_o(on_lpad)
    );

    pong_paddle #(
        .ResolutionSize(ResolutionSize), .YRES(YRES), .PADDLE_X(RPadXI),
        .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H), .PADDLE_SPEED(PADDLE_SPEED)
    ) u_paddle_right (
        .clock(clock), .reset(reset), .tick_i(tick), .up_i(vid.btn[2]), .down_i(vid.btn[3]),
        .x_i(x), .y_i(y), .py_o(rpy), .on_o(on_rpad)
    );

    assign l_overlap = (by_q + BallSz > lpy) && (by_q < lpy + PadH);
    assign r_overlap = (by_q + BallSz > rpy) && (by_q < rpy + PadH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        scorer_d  = scorer_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        if (tick) begin
            unique case (state_q)
                SERVE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(SERVE_FRAMES - 1)) state_d = PLAY;
                end
                PLAY: begin
                    if (dy_q) begin
                        if (by_q + BallSz + Speed >= WallBot) begin
                            by_d = WallBot - BallSz;
                            dy_d = 1'b0;
                        end else begin
                            by_d = by_q + Speed;
                        end
                    end else if (by_q <= WallTop + Speed) begin
                        by_d = WallTop;
                        dy_d = 1'b1;
                    end else begin
                        by_d = by_q - Speed;
                    end
                    // Horizontal resolves from the pre-tick ball and paddle positions.
                    if (dx_q) begin
                        if (bx_q >= HitR && r_overlap) begin
                            bx_d = SnapR;
                            dx_d = 1'b0;
                        end else if (!r_overlap && bx_q >= MissR) begin
                            state_d  = MISS;
                            scorer_d = 1'b1;
                        end else begin
                            bx_d = bx_q + Speed;
                        end
                    end else begin
                        if (bx_q <= HitL && l_overlap) begin
                            bx_d = SnapL;
                            dx_d = 1'b1;
                        end else if (!l_overlap && bx_q <= Speed) begin
                            state_d  = MISS;
                            scorer_d = 1'b0;
                        end else begin
                            bx_d = bx_q - Speed;
                        end
                    end
                end
                MISS: begin
                    if (scorer_q) begin
                        score_l_d = (score_l_q == 4'd9) ? 4'd0 : score_l_q + 4'd1;
                    end else begin
                        score_r_d = (score_r_q == 4'd9) ? 4'd0 : score_r_q + 4'd1;
                    end
                    dx_d    = ~dx_q;
                    bx_d    = BxCtr;
                    by_d    = ByCtr;
                    cnt_d   = '0;
                    state_d = SERVE;
                end
                default: state_d = SERVE;
            endcase
        end
    end

    assign on_ball = (x >= bx_q) && (x < bx_q + BallSz) && (y >= by_q) && (y < by_q + BallSz);

    always_comb begin
        rgb_d = COLOR_BG;
        if (x < XresC && y < YresC) begin
            if (on_ball) begin
                rgb_d = COLOR_BALL;
            end else if (on_lpad || on_rpad) begin
                rgb_d = COLOR_PADDLE;
            end
`ifdef PONG_BORDER_EN
            else if (x < BorderC || x >= XresC - BorderC || y < BorderC || y >= YresC - BorderC) begin
                rgb_d = COLOR_BORDER;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            vsync_prev_q <= 1'b1;
            rgb_q        <= COLOR_BG;
            state_q      <= SERVE;
            cnt_q        <= '0;
            bx_q         <= BxCtr;
            by_q         <= ByCtr;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            scorer_q     <= 1'b0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
        end else begin
            hsync_q      <= vid.hsync_in;
            vsync_q      <= vid.vsync_in;
            vsync_prev_q <= vsync_q;
            rgb_q        <= rgb_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            scorer_q     <= scorer_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
        end
    end

    assign vid.rgb         = rgb_q;
    assign vid.hsync_out   = hsync_q;
    assign vid.vsync_out   = vsync_q;
    assign vid.score_left  = score_l_q;
    assign vid.score_right = score_r_q;

endmodule

// File: doc/pong_frame_renderer.md
# pong_frame_renderer

Pixel-generation stage directly downstream of the CRT timing controller. Consumes its hsync/vsync and (xposition, yposition) and produces an 8-bit RGB332 pixel for a two-paddle Pong playfield. The ball and paddle state advances once per frame. Timing outputs are re-registered so they stay aligned with the one-cycle-late pixel.

## Interface
- ResolutionSize, 10, width of position inputs and object coordinates
- XRES, 640, active pixels per line
- YRES, 480, active lines per frame
- BALL_SIZE, 8, ball side length in pixels
- BALL_SPEED, 2, ball step per frame on each axis
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- PADDLE_X, 16, left paddle left edge; right paddle left edge = XRES-PADDLE_X-PADDLE_W
- PADDLE_SPEED, 4, paddle step per frame
- SERVE_FRAMES, 60, frames the ball is held at centre before play

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- hsync_in, vsync_in  in  1  timing from the CRT controller, active-low
- xposition, yposition  in  ResolutionSize  current pixel coordinates
- btn  in  4  {R_down, R_up, L_down, L_up}; synchronous level inputs
- rgb  out  8  RGB332 pixel
- hsync_out, vsync_out  out  1  hsync_in/vsync_in delayed 1 cycle
- score_left, score_right  out  4  BCD digit 0–9

## Operation
- Frame tick: one-cycle pulse when registered vsync_in goes from 1 to 0 (falling edge). All game state updates only on the tick.
- FSM states: SERVE, PLAY, MISS.
  - SERVE: ball is at (XRES/2-BALL_SIZE/2, YRES/2-BALL_SIZE/2). The frame counter counts ticks; at SERVE_FRAMES ticks the FSM enters PLAY.
  - PLAY: the ball moves BALL_SPEED per tick in direction (dx, dy).
  - MISS: lasts one tick. Increments the scorer's digit (wraps 9→0) and inverts dx so the serve goes toward the scorer. Then enters SERVE with the counter cleared.
- Ball, vertical: if moving up and by ≤ BALL_SPEED, set by=0 and dy flips to down. If moving down and by+BALL_SIZE+BALL_SPEED ≥ YRES, set by=YRES-BALL_SIZE and dy flips.
- Ball, horizontal, moving left:
  - Paddle hit: bx ≤ PADDLE_X+PADDLE_W+BALL_SPEED and vertical overlap (by+BALL_SIZE > lpy and by < lpy+PADDLE_H). Set bx=PADDLE_X+PADDLE_W and dx flips.
  - Miss: no overlap and bx ≤ BALL_SPEED. Go to MISS with the right player scoring.
  - Moving right mirrors this, using the right paddle and right edge XRES-BALL_SIZE.
- Simultaneous wall and paddle events in one tick: both axes resolve independently in the same tick.
- Paddles: up alone moves py by -PADDLE_SPEED, down alone by +PADDLE_SPEED. Both pressed or neither pressed means no move. py is clamped to [0, YRES-PADDLE_H]. Paddles also move during SERVE and MISS.
- All coordinate arithmetic is ResolutionSize+1 bits so the clamp compares cannot wrap.
- Pixel priority: outside active video (x ≥ XRES or y ≥ YRES) gives 8'h00; else ball 8'hFF; else paddle 8'h1C; else border (macro); else 8'h00.
- Coverage tests: ball covers bx ≤ x < bx+BALL_SIZE (same form for y); paddles are analogous.

## Timing
- rgb, hsync_out and vsync_out are registered; latency is 1 clock from xposition/yposition/hsync_in/vsync_in.
- Game state changes exactly one clock after the tick. Because the tick falls in vertical blanking, there is no mid-frame tearing.
- Reset values:
  - rgb=0, hsync_out=1, vsync_out=1, scores=0.
  - FSM=SERVE, frame counter=0.
  - Ball at centre, dx=right, dy=down.
  - Both paddles at py=(YRES-PADDLE_H)/2.
  - Registered vsync=1, so no spurious tick after reset.
- Reset asserted mid-frame returns everything to reset values immediately. Play resumes SERVE_FRAMES ticks after deassertion.

## Configuration
- PONG_BORDER_EN defined: a 4-pixel border (x<4, x≥XRES-4, y<4, y≥YRES-4) is drawn in 8'hE0 at priority below the paddles. The ball's vertical wall limits become 4 and YRES-4-BALL_SIZE instead of 0 and YRES-BALL_SIZE.
- PONG_BORDER_EN undefined: no border pixels and walls at 0/YRES. All other behaviour is identical.

## Structure
- Shared package pong_pkg holds:
  - colour constants (COLOR_BALL, COLOR_PADDLE, COLOR_BORDER, COLOR_BG)
  - FSM state enum (SERVE, PLAY, MISS)
  - border width constant.
- Sub-module pong_paddle, instantiated twice, contains:
  - up/down inputs, tick, clamped py register, reset centre
  - combinational "pixel on paddle" output given x, y and a fixed left-edge parameter.

## Test plan
- Reset then release with no buttons → rgb=8'hFF exactly at pixels (316..323, 236..243) of the next frame, scores 0, paddles at py=208.
- Hold L_up for 60 ticks → left paddle py decreases 4/tick, clamps at 0 after 52 ticks, never underflows. Both L buttons held → py unchanged.
- After serve with no paddle in the path → MISS after bounce path, score_left increments to 1; ten misses wrap the digit to 0.
- Ball aimed at left paddle with overlap → bx snaps to 24, dx reverses, no score change.
- Ball reaches by=472 moving down (2-pixel steps) → next tick by=472 and dy up, and a same-tick paddle hit flips both axes.
- xposition=700, yposition=100 → rgb=8'h00. hsync_out/vsync_out equal inputs delayed exactly 1 clock. With PONG_BORDER_EN, (2,100) → 8'hE0.
